wb_port_arbiter: RTL and testbench
==================================

// Module: wb_port_arbiter
// PURPOSE
//  Single owner of the 64-bit register-file write port (reg_write/rd/write_data) in the pipelined CPU.
//  Merges in-order ALU/load writebacks with out-of-order results from the long-latency mul/div unit (MDU).
//  Buffers MDU results in a small FIFO and keeps a 32-bit pending-register mask for the hazard unit.
//  Sits between the MEM/WB stage plus MDU and the register file.
// PARAMETERS
//  DEPTH  2   MDU result FIFO entries (power of 2, >=2)
//  XLEN   64  data width
// PORTS
//  clk           in   1     rising-edge clock
//  reset         in   1     asynchronous, active-high; clears all state
//  alu_wb_en     in   1     pipeline writeback valid this cycle (never stalled)
//  alu_rd        in   5     pipeline destination register
//  alu_wb_data   in   XLEN  pipeline writeback data
//  issue_valid   in   1     MDU op issued this cycle (reserve destination)
//  issue_rd      in   5     destination of issued MDU op
//  mdu_valid     in   1     MDU result valid
//  mdu_rd        in   5     MDU result destination
//  mdu_data      in   XLEN  MDU result data
//  mdu_ready     out  1     FIFO can accept a result this cycle
//  reg_write     out  1     to regfile write enable (registered)
//  rd            out  5     to regfile destination (registered)
//  write_data    out  XLEN  to regfile data (registered)
//  pending_mask  out  32    bit i = MDU write to xi outstanding
//  fifo_count    out  $clog2(DEPTH)+1  MDU entries buffered
// BEHAVIOUR
//  - Reset (async): reg_write=0, rd=0, write_data=0, pending_mask=0, FIFO empty (fifo_count=0), mdu_ready=1.
//  - mdu_ready = (fifo_count < DEPTH), combinational from the count only; no same-cycle pop credit when full.
//  - Push: mdu_valid && mdu_ready writes {mdu_rd, mdu_data} at the tail.
//  - Push while not ready: the result is not accepted; the MDU holds it.
//  - Arbitration per cycle, ALU has strict priority:
//    - alu_wb_en=1: ALU entry selected; the FIFO does not pop.
//    - alu_wb_en=0 and FIFO non-empty: the head pops and is selected.
//    - Otherwise nothing is selected.
//  - Push of an empty FIFO is not visible at the head until the next cycle, so FIFO latency is >=1 cycle.
//  - Output register, 1-cycle latency. At posedge:
//    - reg_write <= selected && sel_rd!=0; rd/write_data <= selected fields.
//    - If nothing is selected: reg_write <= 0, rd/write_data hold.
//  - x0: entries with rd=0 are still consumed/popped but never assert reg_write.
//  - Simultaneous push+pop: both occur and count is unchanged; pointers wrap modulo DEPTH.
//  - pending_mask:
//    - Set: issue_valid && issue_rd!=0 sets bit issue_rd.
//    - Clear: an MDU-sourced selection with mdu rd!=0 clears bit rd in the same edge the output register loads.
//    - The bit therefore drops in the same cycle reg_write is first visible.
//    - Set and clear of the same bit in one cycle: set wins (new op reserved).
//    - ALU writebacks never touch pending_mask.
//  - No FSM beyond FIFO pointers/count. The regfile sees at most one write per cycle by construction.
//  - Reset mid-operation discards buffered results and the mask; the MDU is reset by the same reset.
// TESTING
//  1. Reset mid-traffic:
//     - Stimulus: reset with outputs nonzero -> outputs, mask and count 0 immediately (async).
//     - Then deassert: mdu_ready=1.
//  2. ALU only:
//     - Stimulus: alu_wb_en=1, alu_rd=5, data=0xDEAD_BEEF_0000_0001.
//     - Required: next cycle reg_write=1, rd=5, write_data matches.
//  3. MDU through FIFO:
//     - Stimulus: issue_rd=7, then mdu_valid with rd=7, data=0x2A.
//     - Required: mask[7]=1 until reg_write with rd=7, data=0x2A, 2 cycles after push; mask[7] then 0.
//  4. Priority/backpressure:
//     - Stimulus: ALU writes 4 consecutive cycles while MDU pushes rd 8,9,10.
//     - Required: mdu_ready=0 once count=2; third result held; ALU writes appear back-to-back.
//     - Then FIFO drains 8,9,10 in order.
//  5. x0 handling:
//     - ALU rd=0 and MDU rd=0 -> reg_write never 1; FIFO entry still popped (count decrements).
//     - issue_rd=0 -> mask unchanged.
//  6. Set/clear collision:
//     - Stimulus: MDU result rd=3 commits in the same cycle issue_valid with rd=3.
//     - Required: mask[3] stays 1.

Source files
------------

// File: rtl/wb_port_arbiter.sv
// Register-file write-port owner: merges in-order ALU writebacks with buffered
// out-of-order MDU results and tracks outstanding MDU destinations for hazards.
module wb_port_arbiter #(
   parameter int DEPTH = 2,
   parameter int XLEN  = 64
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     alu_wb_en,
   input  logic [4:0]               alu_rd,
   input  logic [XLEN-1:0]          alu_wb_data,
   input  logic                     issue_valid,
   input  logic [4:0]               issue_rd,
   input  logic                     mdu_valid,
   input  logic [4:0]               mdu_rd,
   input  logic [XLEN-1:0]          mdu_data,
   output logic                     mdu_ready,
   output logic                     reg_write,
   output logic [4:0]               rd,
   output logic [XLEN-1:0]          write_data,
   output logic [31:0]              pending_mask,
   output logic [$clog2(DEPTH):0]   fifo_count
);
   localparam int AW    = $clog2(DEPTH);
   localparam int CNT_W = AW + 1;

   logic [4:0]      r_q_rd   [DEPTH];
   logic [XLEN-1:0] r_q_data [DEPTH];
   logic [AW-1:0]   r_wr_ptr, r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic            r_reg_write;
   logic [4:0]      r_rd;
   logic [XLEN-1:0] r_write_data;
   logic [31:0]     r_mask;

   logic            w_push, w_pop, w_sel;
   logic [4:0]      w_sel_rd;
   logic [XLEN-1:0] w_sel_data;
   logic [31:0]     w_set, w_clr;

   // Ready looks at the count only: a full FIFO never takes credit for a same-cycle pop.
   assign mdu_ready = (r_count < CNT_W'(DEPTH));
   assign w_push    = mdu_valid && mdu_ready;
   assign w_pop     = !alu_wb_en && (r_count != '0);

   always_comb begin
      w_sel      = 1'b0;
      w_sel_rd   = '0;
      w_sel_data = '0;
      if (alu_wb_en) begin
         w_sel      = 1'b1;
         w_sel_rd   = alu_rd;
         w_sel_data = alu_wb_data;
      end else if (w_pop) begin
         w_sel      = 1'b1;
         w_sel_rd   = r_q_rd[r_rd_ptr];
         w_sel_data = r_q_data[r_rd_ptr];
      end
   end

   always_comb begin
      w_set = '0;
      w_clr = '0;
      if (issue_valid && issue_rd != 5'd0)
         w_set[issue_rd] = 1'b1;
      if (w_pop && r_q_rd[r_rd_ptr] != 5'd0)
         w_clr[r_q_rd[r_rd_ptr]] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_q_rd[r_wr_ptr]   <= mdu_rd;
         r_q_data[r_wr_ptr] <= mdu_data;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wr_ptr     <= '0;
         r_rd_ptr     <= '0;
         r_count      <= '0;
         r_reg_write  <= 1'b0;
         r_rd         <= '0;
         r_write_data <= '0;
         r_mask       <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
         r_reg_write <= w_sel && (w_sel_rd != 5'd0);
         if (w_sel) begin
            r_rd         <= w_sel_rd;
            r_write_data <= w_sel_data;
         end
         // Set after clear so a freshly issued op keeps its reservation.
         r_mask <= (r_mask & ~w_clr) | w_set;
      end
   end

   assign reg_write    = r_reg_write;
   assign rd           = r_rd;
   assign write_data   = r_write_data;
   assign pending_mask = r_mask;
   assign fifo_count   = r_count;
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed vector bench for wb_port_arbiter: a table of per-cycle stimulus with
// hand-computed post-edge outputs, plus explicit async-reset sequences.
module tb_wb_port_arbiter;
   logic        clk = 1'b0;
   logic        reset;
   logic        alu_wb_en, issue_valid, mdu_valid;
   logic [4:0]  alu_rd, issue_rd, mdu_rd;
   logic [63:0] alu_wb_data, mdu_data;
   logic        mdu_ready, reg_write;
   logic [4:0]  rd;
   logic [63:0] write_data;
   logic [31:0] pending_mask;
   logic [1:0]  fifo_count;

   int checks = 0;
   int failures = 0;

   wb_port_arbiter #(.DEPTH(2), .XLEN(64)) dut (
      .clk(clk), .reset(reset),
      .alu_wb_en(alu_wb_en), .alu_rd(alu_rd), .alu_wb_data(alu_wb_data),
      .issue_valid(issue_valid), .issue_rd(issue_rd),
      .mdu_valid(mdu_valid), .mdu_rd(mdu_rd), .mdu_data(mdu_data),
      .mdu_ready(mdu_ready), .reg_write(reg_write), .rd(rd),
      .write_data(write_data), .pending_mask(pending_mask), .fifo_count(fifo_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        alu_en;
      logic [4:0]  alu_rd;
      logic [63:0] alu_data;
      logic        iss_v;
      logic [4:0]  iss_rd;
      logic        mdu_v;
      logic [4:0]  mdu_rd;
      logic [63:0] mdu_data;
      logic        e_rw;
      logic [4:0]  e_rd;
      logic [63:0] e_wd;
      logic [31:0] e_mask;
      logic [1:0]  e_cnt;
      logic        e_rdy;
   } vec_t;

   localparam int NV = 23;
   vec_t vecs[NV];

   function automatic vec_t mk(logic ae, logic [4:0] ar, logic [63:0] ad,
                               logic iv, logic [4:0] ir,
                               logic mv, logic [4:0] mr, logic [63:0] md,
                               logic erw, logic [4:0] erd, logic [63:0] ewd,
                               logic [31:0] em, logic [1:0] ec, logic ery);
      vec_t v;
      v.alu_en = ae; v.alu_rd = ar; v.alu_data = ad;
      v.iss_v = iv; v.iss_rd = ir;
      v.mdu_v = mv; v.mdu_rd = mr; v.mdu_data = md;
      v.e_rw = erw; v.e_rd = erd; v.e_wd = ewd;
      v.e_mask = em; v.e_cnt = ec; v.e_rdy = ery;
      return v;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic erw, input logic [4:0] erd,
                          input logic [63:0] ewd, input logic [31:0] em,
                          input logic [1:0] ec, input logic ery);
      chk({tag, ".reg_write"}, 64'(reg_write), 64'(erw));
      chk({tag, ".rd"}, 64'(rd), 64'(erd));
      chk({tag, ".write_data"}, write_data, ewd);
      chk({tag, ".mask"}, 64'(pending_mask), 64'(em));
      chk({tag, ".count"}, 64'(fifo_count), 64'(ec));
      chk({tag, ".ready"}, 64'(mdu_ready), 64'(ery));
   endtask

   task automatic drive_idle();
      alu_wb_en = 0; alu_rd = 0; alu_wb_data = 0;
      issue_valid = 0; issue_rd = 0;
      mdu_valid = 0; mdu_rd = 0; mdu_data = 0;
   endtask

   initial begin
      // ALU-only write, MDU round trip with mask, priority/backpressure, x0, set/clear collision
      vecs[0]  = mk(1, 5, 64'hDEAD_BEEF_0000_0001, 0, 0, 0, 0, 0, 1, 5, 64'hDEAD_BEEF_0000_0001, 0, 0, 1);
      vecs[1]  = mk(0, 0, 0, 1, 7, 0, 0, 0,         0, 5, 64'hDEAD_BEEF_0000_0001, 32'h80, 0, 1);
      vecs[2]  = mk(0, 0, 0, 0, 0, 1, 7, 64'h2A,    0, 5, 64'hDEAD_BEEF_0000_0001, 32'h80, 1, 1);
      vecs[3]  = mk(0, 0, 0, 0, 0, 0, 0, 0,         1, 7, 64'h2A, 0, 0, 1);
      vecs[4]  = mk(1, 11, 64'h111, 0, 0, 1, 8, 64'h800,  1, 11, 64'h111, 0, 1, 1);
      vecs[5]  = mk(1, 12, 64'h122, 0, 0, 1, 9, 64'h900,  1, 12, 64'h122, 0, 2, 0);
      vecs[6]  = mk(1, 13, 64'h133, 0, 0, 1, 10, 64'hA00, 1, 13, 64'h133, 0, 2, 0);
      vecs[7]  = mk(1, 14, 64'h144, 0, 0, 1, 10, 64'hA00, 1, 14, 64'h144, 0, 2, 0);
      vecs[8]  = mk(0, 0, 0, 0, 0, 1, 10, 64'hA00,        1, 8, 64'h800, 0, 1, 1);
      vecs[9]  = mk(0, 0, 0, 0, 0, 1, 10, 64'hA00,        1, 9, 64'h900, 0, 1, 1);
      vecs[10] = mk(0, 0, 0, 0, 0, 0, 0, 0,               1, 10, 64'hA00, 0, 0, 1);
      vecs[11] = mk(0, 0, 0, 0, 0, 0, 0, 0,               0, 10, 64'hA00, 0, 0, 1);
      vecs[12] = mk(1, 0, 64'h55, 1, 0, 0, 0, 0,          0, 0, 64'h55, 0, 0, 1);
      vecs[13] = mk(0, 0, 0, 0, 0, 1, 0, 64'h66,          0, 0, 64'h55, 0, 1, 1);
      vecs[14] = mk(0, 0, 0, 0, 0, 0, 0, 0,               0, 0, 64'h66, 0, 0, 1);
      vecs[15] = mk(0, 0, 0, 1, 3, 0, 0, 0,               0, 0, 64'h66, 32'h8, 0, 1);
      vecs[16] = mk(0, 0, 0, 0, 0, 1, 3, 64'h33,          0, 0, 64'h66, 32'h8, 1, 1);
      vecs[17] = mk(0, 0, 0, 1, 3, 0, 0, 0,               1, 3, 64'h33, 32'h8, 0, 1);
      vecs[18] = mk(0, 0, 0, 0, 0, 0, 0, 0,               0, 3, 64'h33, 32'h8, 0, 1);
      vecs[19] = mk(0, 0, 0, 0, 0, 1, 3, 64'h44,          0, 3, 64'h33, 32'h8, 1, 1);
      vecs[20] = mk(0, 0, 0, 0, 0, 0, 0, 0,               1, 3, 64'h44, 0, 0, 1);
      vecs[21] = mk(1, 3, 64'h99, 1, 3, 0, 0, 0,          1, 3, 64'h99, 32'h8, 0, 1);
      vecs[22] = mk(1, 3, 64'hAA, 0, 0, 0, 0, 0,          1, 3, 64'hAA, 32'h8, 0, 1);

      drive_idle();
      reset = 1'b1;
      #2;
      chk_all("por", 0, 0, 0, 0, 0, 1);
      @(posedge clk); #1;
      reset = 1'b0;

      for (int i = 0; i < NV; i++) begin
         alu_wb_en = vecs[i].alu_en; alu_rd = vecs[i].alu_rd; alu_wb_data = vecs[i].alu_data;
         issue_valid = vecs[i].iss_v; issue_rd = vecs[i].iss_rd;
         mdu_valid = vecs[i].mdu_v; mdu_rd = vecs[i].mdu_rd; mdu_data = vecs[i].mdu_data;
         @(posedge clk); #1;
         chk_all($sformatf("v%0d", i), vecs[i].e_rw, vecs[i].e_rd, vecs[i].e_wd,
                 vecs[i].e_mask, vecs[i].e_cnt, vecs[i].e_rdy);
      end

      // Reset mid-traffic: outputs nonzero, one entry buffered, mask bit 3 and 20 set
      alu_wb_en = 1; alu_rd = 9; alu_wb_data = 64'h77;
      issue_valid = 1; issue_rd = 20;
      mdu_valid = 1; mdu_rd = 4; mdu_data = 64'h4444;
      @(posedge clk); #1;
      drive_idle();
      chk_all("pre_rst", 1, 9, 64'h77, 32'h0010_0008, 1, 1);
      #2;
      reset = 1'b1;
      #1;
      chk_all("async_rst", 0, 0, 0, 0, 0, 1);
      @(posedge clk); #1;
      reset = 1'b0;
      chk_all("rst_release", 0, 0, 0, 0, 0, 1);
      @(posedge clk); #1;
      chk_all("post_rst_idle", 0, 0, 0, 0, 0, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
